shifter_planar_packer: RTL and testbench

//  Encoder counterpart of the ST shifter video path: accepts one 4-bit colour index per pixel

---
 rtl/shifter_pkg.sv | 23 ++
 rtl/shifter_planar_packer_if.sv | 29 ++
 rtl/shifter_plane_acc.sv | 69 ++++++
 rtl/shifter_planar_packer.sv | 95 +++++++++
 tb/tb_shifter_planar_packer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the planar packer: rez codes, per-rez word count, emit FSM states.
package shifter_pkg;

  localparam logic [1:0] REZ_LOW  = 2'b00;
  localparam logic [1:0] REZ_MID  = 2'b01;
  localparam logic [1:0] REZ_HIGH = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } emit_state_e;

  // Number of bitplane words a 16-pixel group occupies in memory for a given rez.
  function automatic logic [2:0] words_per_rez(input logic [1:0] rez);
    case (rez)
      REZ_LOW:  return 3'd4;
      REZ_MID:  return 3'd2;
      REZ_HIGH: return 3'd1;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/shifter_planar_packer_if.sv
// Pixel input side and plane-word output stream of the planar packer.
interface shifter_planar_packer_if;

  logic        pixClkEn;
  logic        DE;
  logic [1:0]  rez;
  logic [3:0]  color_index;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  dout_plane;
  logic        dout_last;
  logic        dout_ready;
  logic        ovf_clr;
  logic        overflow;
  logic        busy;

  // Pixel source / word consumer side.
  modport master (
    output pixClkEn, DE, rez, color_index, dout_ready, ovf_clr,
    input  dout, dout_valid, dout_plane, dout_last, overflow, busy
  );

  // Packer side.
  modport slave (
    input  pixClkEn, DE, rez, color_index, dout_ready, ovf_clr,
    output dout, dout_valid, dout_plane, dout_last, overflow, busy
  );

endinterface

// File: rtl/shifter_plane_acc.sv
// Four 16-bit plane shift registers with pixel counter, per-group rez latch and
// zero-filled flush of a partial group when DE falls.
module shifter_plane_acc
  import shifter_pkg::*;
#(
  parameter bit FLUSH_ON_DE = 1'b1
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        de,
  input  logic [1:0]  rez,
  input  logic [3:0]  color_index,
  output logic        group_done,
  output logic [63:0] group_bits,
  output logic [2:0]  group_words,
  output logic        partial
);

  logic [15:0] pl      [4];
  logic [15:0] pl_next [4];
  logic [3:0]  count;
  logic [1:0]  rez_q;
  logic        de_q;
  logic [1:0]  eff_rez;
  logic        de_fall;
  logic        do_flush;
  logic [4:0]  fill_sh;

  // Next plane contents, group completion and the zero-filled flush image.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    eff_rez     = (count == 4'd0) ? rez : rez_q;
    de_fall     = de_q & ~de;
    do_flush    = FLUSH_ON_DE && de_fall && (count != 4'd0);
    fill_sh     = 5'd16 - {1'b0, count};
    group_done  = (pix_en && (count == 4'd15)) || do_flush;
    group_words = words_per_rez(eff_rez);
    partial     = (count != 4'd0);
    group_bits  = '0;
    for (int p = 0; p < 4; p++) begin
      // Planes beyond the rez's word count also shift; their contents are never emitted.
      pl_next[p] = {pl[p][14:0], color_index[p]};
      group_bits[p*16 +: 16] = do_flush ? (pl[p] << fill_sh) : pl_next[p];
    end
  end

  // Shift accepted pixels in MSB-first, count them, latch rez at the first pixel of a group.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      // NOTE: the plane registers are small and cleared on reset so no stale bits survive an abort.
      pl    <= '{default: '0};
      count <= '0;
      rez_q <= REZ_LOW;
      de_q  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      de_q <= de;
      if (pix_en) begin
        for (int p = 0; p < 4; p++) pl[p] <= pl_next[p];
        count <= count + 4'd1;
        if (count == 4'd0) rez_q <= rez;
      end else if (de_fall) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/shifter_planar_packer.sv
// Packs 4-bit colour indices into interleaved bitplane words and streams them
// plane 0 first over a valid/ready port, with a one-group holding buffer.
module shifter_planar_packer
  import shifter_pkg::*;
#(
  parameter bit FLUSH_ON_DE = 1'b1
) (
  input  logic clk32,
  input  logic reset,
  shifter_planar_packer_if.slave bus
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_EMIT = EMIT;

  logic        group_done;
  logic [63:0] group_bits;
  logic [2:0]  group_words;
  logic        partial;

  logic [0:0]  state;
  logic [15:0] hold [4];
  logic [2:0]  n_words;
  logic [1:0]  k;
  logic        overflow_q;

  logic        emitting;
  logic        last_word;
  logic        xfer;
  logic        last_xfer;
  logic        capture;

  shifter_plane_acc #(
    .FLUSH_ON_DE (FLUSH_ON_DE)
  ) u_acc (
    .clk32       (clk32),
    .reset       (reset),
    .pix_en      (bus.pixClkEn & bus.DE),
    .de          (bus.DE),
    .rez         (bus.rez),
    .color_index (bus.color_index),
    .group_done  (group_done),
    .group_bits  (group_bits),
    .group_words (group_words),
    .partial     (partial)
  );

  // Handshake decode: a new group is taken when idle or as the last word leaves.
  always_comb begin
    emitting  = (state == ST_EMIT);
    last_word = ({1'b0, k} == (n_words - 3'd1));
    xfer      = emitting & bus.dout_ready;
    last_xfer = xfer & last_word;
    capture   = group_done & (~emitting | last_xfer);
  end

  assign bus.dout       = emitting ? hold[k] : 16'h0000;
  assign bus.dout_valid = emitting;
  assign bus.dout_plane = k;
  assign bus.dout_last  = emitting & last_word;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = emitting | partial;

  // Emit FSM: load holding buffer on capture, step plane index on each transfer.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold    <= '{default: '0};
      n_words <= '0;
      k       <= '0;
    end else if (capture) begin
      for (int p = 0; p < 4; p++) hold[p] <= group_bits[p*16 +: 16];
      n_words <= group_words;
      k       <= '0;
      state   <= ST_EMIT;
    end else if (last_xfer) begin
      state <= ST_IDLE;
      k     <= '0;
    end else if (xfer) begin
      k <= k + 2'd1;
    end
  end

  // Sticky overflow for groups dropped while the buffer is occupied; set beats clear.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (group_done && !capture) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_planar_packer.sv
// Directed and randomized bench for shifter_planar_packer against a pixel-list model.
module tb_shifter_planar_packer;

  typedef struct {
    logic [15:0] word;
    logic [1:0]  plane;
    logic        last;
  } exp_t;

  logic clk32 = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q [$];

  always #5 clk32 = ~clk32;

  shifter_planar_packer_if bus ();
  shifter_planar_packer_if bus_nf ();

  shifter_planar_packer #(.FLUSH_ON_DE(1'b1)) dut (
    .clk32 (clk32),
    .reset (reset),
    .bus   (bus.slave)
  );

  shifter_planar_packer #(.FLUSH_ON_DE(1'b0)) dut_nf (
    .clk32 (clk32),
    .reset (reset),
    .bus   (bus_nf.slave)
  );

  assign bus_nf.pixClkEn    = bus.pixClkEn;
  assign bus_nf.DE          = bus.DE;
  assign bus_nf.rez         = bus.rez;
  assign bus_nf.color_index = bus.color_index;
  assign bus_nf.dout_ready  = bus.dout_ready;
  assign bus_nf.ovf_clr     = bus.ovf_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word for plane p: pixel i contributes colour bit p at weight 2^(15-i); missing pixels are 0.
  function automatic logic [15:0] plane_word(input logic [3:0] px [$], input int p);
    logic [15:0] w = 16'h0000;
    for (int i = 0; i < px.size(); i++)
      if (px[i][p]) w = w | (16'h8000 >> i);
    return w;
  endfunction

  function automatic int words_for(input logic [1:0] rez);
    if (rez == 2'd0) return 4;
    if (rez == 2'd1) return 2;
    return 1;
  endfunction

  task automatic push_group(input logic [3:0] px [$], input logic [1:0] rez);
    int n = words_for(rez);
    for (int p = 0; p < n; p++) begin
      exp_t e;
      e.word  = plane_word(px, p);
      e.plane = 2'(p);
      e.last  = (p == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: scoreboard any transfer at the negedge, then return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk32);
    if (mon_en && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(bus.dout_valid), 0);
      end else begin
        exp_t e = exp_q.pop_front();
        check("rnd_dout", 32'(bus.dout), 32'(e.word));
        check("rnd_plane", 32'(bus.dout_plane), 32'(e.plane));
        check("rnd_last", 32'(bus.dout_last), 32'(e.last));
      end
    end
    @(posedge clk32);
    #1;
  endtask

  task automatic pix(input logic [3:0] ci);
    bus.pixClkEn    = 1'b1;
    bus.color_index = ci;
    tick();
    bus.pixClkEn    = 1'b0;
  endtask

  task automatic expect_words(input string tag, input logic [3:0] px [$], input int n);
    for (int p = 0; p < n; p++) begin
      check({tag, "_valid"}, 32'(bus.dout_valid), 1);
      check({tag, "_dout"}, 32'(bus.dout), 32'(plane_word(px, p)));
      check({tag, "_plane"}, 32'(bus.dout_plane), 32'(p));
      check({tag, "_last"}, 32'(bus.dout_last), 32'(p == n - 1));
      tick();
    end
    check({tag, "_done"}, 32'(bus.dout_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] t1_exp [4];
    logic [3:0]  ga [$];
    logic [3:0]  gb [$];
    logic [3:0]  cur [$];
    logic [1:0]  cur_rez;
    bit          prev_stall;

    t1_exp = '{16'h5555, 16'h3333, 16'h0F0F, 16'h00FF};

    reset           = 1'b1;
    bus.pixClkEn    = 1'b0;
    bus.DE          = 1'b0;
    bus.rez         = 2'd0;
    bus.color_index = 4'd0;
    bus.dout_ready  = 1'b0;
    bus.ovf_clr     = 1'b0;
    #12;
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_plane", 32'(bus.dout_plane), 0);
    check("rst_last", 32'(bus.dout_last), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk32);
    reset = 1'b0;
    @(posedge clk32);
    #1;

    // Low rez ramp: first valid exactly one cycle after the 16th pixel.
    bus.DE = 1'b1;
    bus.rez = 2'd0;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 15; i++) pix(4'(i));
    check("t1_no_early_valid", 32'(bus.dout_valid), 0);
    check("t1_busy_partial", 32'(bus.busy), 1);
    pix(4'd15);
    for (int p = 0; p < 4; p++) begin
      check("t1_valid", 32'(bus.dout_valid), 1);
      check("t1_dout", 32'(bus.dout), 32'(t1_exp[p]));
      check("t1_plane", 32'(bus.dout_plane), 32'(p));
      check("t1_last", 32'(bus.dout_last), 32'(p == 3));
      tick();
    end
    check("t1_done", 32'(bus.dout_valid), 0);

    // Mid rez, upper colour bits set but ignored.
    bus.rez = 2'd1;
    for (int i = 0; i < 16; i++) pix((i % 2 == 0) ? 4'hF : 4'hC);
    for (int p = 0; p < 2; p++) begin
      check("t2_dout", 32'(bus.dout), 'hAAAA);
      check("t2_plane", 32'(bus.dout_plane), 32'(p));
      check("t2_last", 32'(bus.dout_last), 32'(p == 1));
      tick();
    end
    check("t2_done", 32'(bus.dout_valid), 0);

    // High rez; rez switches to low after the first pixel and must be ignored.
    bus.rez = 2'd2;
    for (int i = 0; i < 16; i++) begin
      pix(((i / 2) % 2 == 0) ? 4'hF : 4'hE);
      bus.rez = 2'd0;
    end
    check("t3_dout", 32'(bus.dout), 'hCCCC);
    check("t3_plane", 32'(bus.dout_plane), 0);
    check("t3_last", 32'(bus.dout_last), 1);
    tick();
    check("t3_done", 32'(bus.dout_valid), 0);

    // Overflow: buffer held, second group dropped; set beats clear.
    bus.rez = 2'd0;
    bus.dout_ready = 1'b0;
    ga.delete();
    repeat (16) ga.push_back(4'($urandom));
    foreach (ga[i]) pix(ga[i]);
    check("t4_held_valid", 32'(bus.dout_valid), 1);
    repeat (16) pix(4'($urandom));
    check("t4_overflow", 32'(bus.overflow), 1);
    check("t4_held_dout", 32'(bus.dout), 32'(plane_word(ga, 0)));
    check("t4_held_plane", 32'(bus.dout_plane), 0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t4_ovf_cleared", 32'(bus.overflow), 0);
    repeat (15) pix(4'($urandom));
    bus.ovf_clr = 1'b1;
    pix(4'($urandom));
    bus.ovf_clr = 1'b0;
    check("t4_set_wins", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    bus.dout_ready = 1'b1;
    expect_words("t4_drain", ga, 4);

    // Last word of one group leaves in the same cycle the next group completes.
    bus.dout_ready = 1'b0;
    ga.delete();
    gb.delete();
    repeat (16) ga.push_back(4'($urandom));
    repeat (16) gb.push_back(4'($urandom));
    foreach (ga[i]) pix(ga[i]);
    for (int j = 0; j < 16; j++) begin
      if (j >= 12) begin
        bus.dout_ready = 1'b1;
        check("t5_prev_dout", 32'(bus.dout), 32'(plane_word(ga, j - 12)));
      end
      pix(gb[j]);
    end
    check("t5_no_overflow", 32'(bus.overflow), 0);
    expect_words("t5_next", gb, 4);

    // Flush on DE fall: 5 pixels of F become four 0xF800 words; no-flush variant emits nothing.
    ga.delete();
    repeat (5) ga.push_back(4'hF);
    foreach (ga[i]) pix(ga[i]);
    bus.DE = 1'b0;
    tick();
    check("t6_nf_valid", 32'(bus_nf.dout_valid), 0);
    check("t6_nf_busy", 32'(bus_nf.busy), 0);
    for (int p = 0; p < 4; p++) begin
      check("t6_dout", 32'(bus.dout), 'hF800);
      check("t6_plane", 32'(bus.dout_plane), 32'(p));
      check("t6_last", 32'(bus.dout_last), 32'(p == 3));
      tick();
    end
    check("t6_done", 32'(bus.dout_valid), 0);
    check("t6_nf_quiet", 32'(bus_nf.dout_valid), 0);
    bus.DE = 1'b1;
    tick();
    bus.DE = 1'b0;
    tick();
    tick();
    check("t6_empty_fall", 32'(bus.dout_valid), 0);
    check("t6_empty_busy", 32'(bus.busy), 0);

    // Reset while word 2 is presented, with a partial group pending.
    bus.DE = 1'b1;
    bus.dout_ready = 1'b0;
    repeat (16) pix(4'($urandom));
    bus.dout_ready = 1'b1;
    tick();
    tick();
    bus.dout_ready = 1'b0;
    check("t7_at_word2", 32'(bus.dout_plane), 2);
    repeat (3) pix(4'($urandom));
    reset = 1'b1;
    #2;
    check("t7_rst_valid", 32'(bus.dout_valid), 0);
    check("t7_rst_dout", 32'(bus.dout), 0);
    check("t7_rst_plane", 32'(bus.dout_plane), 0);
    check("t7_rst_last", 32'(bus.dout_last), 0);
    check("t7_rst_busy", 32'(bus.busy), 0);
    @(negedge clk32);
    reset = 1'b0;
    @(posedge clk32);
    #1;
    bus.dout_ready = 1'b1;
    ga.delete();
    repeat (16) ga.push_back(4'($urandom));
    for (int i = 0; i < 13; i++) pix(ga[i]);
    check("t7_no_stale", 32'(bus.dout_valid), 0);
    for (int i = 13; i < 16; i++) pix(ga[i]);
    expect_words("t7_new", ga, 4);

    // Randomized traffic: random rez per pixel, random strobes, occasional DE drops and stalls.
    bus.DE = 1'b1;
    tick();
    mon_en = 1'b1;
    cur.delete();
    cur_rez = 2'd0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.rez         = 2'($urandom_range(0, 3));
      bus.color_index = 4'($urandom);
      bus.pixClkEn    = 1'($urandom_range(0, 1));
      bus.DE          = !((cur.size() >= 8) && ($urandom_range(0, 19) == 0));
      bus.dout_ready  = prev_stall || ($urandom_range(0, 6) != 0);
      prev_stall      = !bus.dout_ready;
      if (bus.pixClkEn && bus.DE) begin
        if (cur.size() == 0) cur_rez = bus.rez;
        cur.push_back(bus.color_index);
        if (cur.size() == 16) begin
          push_group(cur, cur_rez);
          cur.delete();
        end
      end else if (!bus.DE && cur.size() > 0) begin
        push_group(cur, cur_rez);
        cur.delete();
      end
      tick();
    end
    bus.pixClkEn   = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (10) tick();
    check("rnd_all_words_seen", 32'(exp_q.size()), 0);
    check("rnd_no_overflow", 32'(bus.overflow), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
